// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for a single req/gnt/rvalid data-bus slave port.
// Granted master IDs are queued in grant order so that responses can be routed back in order.
module data_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ROUND_ROBIN     = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [6:0]  m0_wdata_intg,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic [6:0]  m0_rdata_intg,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [6:0]  m1_wdata_intg,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [6:0]  m1_rdata_intg,
  output logic        m1_err,

  output logic        s_req,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [6:0]  s_wdata_intg,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  input  logic [6:0]  s_rdata_intg,
  input  logic        s_err,

  output logic        resp_unexpected
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  master_e          id_q [MAX_OUTSTANDING];
  master_e          id_d [MAX_OUTSTANDING];
  master_e          last_grant_q, last_grant_d;
  logic             resp_unexpected_q, resp_unexpected_d;

  master_e sel;
  master_e head;
  logic    fifo_full;
  logic    fifo_empty;
  logic    push;
  logic    pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head       = id_q[rd_ptr_q];

  // On contention, round-robin favours whichever master was not granted last.
  always_comb begin
    sel = MST_M0;
    if (m0_req && m1_req) begin
      if (ROUND_ROBIN != 0) begin
        sel = (last_grant_q == MST_M0) ? MST_M1 : MST_M0;
      end else begin
        sel = MST_M0;
      end
    end else if (m1_req) begin
      sel = MST_M1;
    end
  end

  always_comb begin
    s_req        = (m0_req | m1_req) & ~fifo_full;
    s_we         = 1'b0;
    s_be         = '0;
    s_addr       = '0;
    s_wdata      = '0;
    s_wdata_intg = '0;
    if (s_req) begin
      if (sel == MST_M1) begin
        s_we         = m1_we;
        s_be         = m1_be;
        s_addr       = m1_addr;
        s_wdata      = m1_wdata;
        s_wdata_intg = m1_wdata_intg;
      end else begin
        s_we         = m0_we;
        s_be         = m0_be;
        s_addr       = m0_addr;
        s_wdata      = m0_wdata;
        s_wdata_intg = m0_wdata_intg;
      end
    end
  end

  assign push   = s_req & s_gnt;
  assign pop    = s_rvalid & ~fifo_empty;

  assign m0_gnt = push & (sel == MST_M0);
  assign m1_gnt = push & (sel == MST_M1);

  assign m0_rvalid     = pop & (head == MST_M0);
  assign m1_rvalid     = pop & (head == MST_M1);
  assign m0_err        = m0_rvalid & s_err;
  assign m1_err        = m1_rvalid & s_err;
  assign m0_rdata      = s_rdata;
  assign m1_rdata      = s_rdata;
  assign m0_rdata_intg = s_rdata_intg;
  assign m1_rdata_intg = s_rdata_intg;

  assign resp_unexpected = resp_unexpected_q;

  // Simultaneous push and pop leaves the count unchanged; the freed slot only
  // becomes usable next cycle because fifo_full is derived from cnt_q.
  always_comb begin
    id_d              = id_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    cnt_d             = cnt_q;
    last_grant_d      = last_grant_q;
    resp_unexpected_d = resp_unexpected_q;

    if (push) begin
      id_d[wr_ptr_q] = sel;
      wr_ptr_d       = ptr_inc(wr_ptr_q);
      last_grant_d   = sel;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (s_rvalid && fifo_empty) begin
      resp_unexpected_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q             <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      id_q              <= '{default: MST_M0};
      last_grant_q      <= MST_M1;
      resp_unexpected_q <= 1'b0;
    end else begin
      cnt_q             <= cnt_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      id_q              <= id_d;
      last_grant_q      <= last_grant_d;
      resp_unexpected_q <= resp_unexpected_d;
    end
  end

endmodule
